// File: rtl/mux_pkg.sv
// rtl/mux_pkg.sv - shared constants and types for the registered N:1 mux
package mux_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } mux_state_t;

    localparam int STALL_W = 16;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational rotating-priority picker (first request at or after ptr)
module rr_pick #(
    parameter int NUM_CH = 4,
    parameter int SEL_W  = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [SEL_W-1:0]  ptr,
    output logic [SEL_W-1:0]  gnt,
    output logic              gnt_vld
);

    function automatic int wrap_idx(input int base, input int ofs);
        return (base + ofs) % NUM_CH;
    endfunction

    always_comb begin
        gnt     = '0;
        gnt_vld = 1'b0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (!gnt_vld && req[wrap_idx(int'(ptr), k)]) begin
                gnt_vld = 1'b1;
                gnt     = SEL_W'(wrap_idx(int'(ptr), k));
            end
        end
    end

endmodule

// File: rtl/mux_nx1_rr.sv
// rtl/mux_nx1_rr.sv - registered N:1 mux, fixed or round-robin select; optional MUX_STALL_CNT_EN
module mux_nx1_rr
    import mux_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 8,
    localparam int SEL_W = $clog2(NUM_CH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     mode,
    input  logic [SEL_W-1:0]         sel,
    input  logic [NUM_CH-1:0]        in_valid,
    input  logic [NUM_CH*DATA_W-1:0] in_data,
    output logic [NUM_CH-1:0]        in_ready,
    output logic                     out_valid,
    output logic [DATA_W-1:0]        out_data,
    output logic [SEL_W-1:0]         out_ch,
`ifdef MUX_STALL_CNT_EN
    output logic [STALL_W-1:0]       stall_cnt,
`endif
    input  logic                     out_ready
);

    localparam int SEL_SPAN = 1 << SEL_W;

    mux_state_t          state;
    mux_state_t          state_nxt;
    logic [SEL_W-1:0]    ptr;
    logic [SEL_W-1:0]    rr_gnt;
    logic                rr_vld;
    logic [SEL_W-1:0]    gnt;
    logic                gnt_vld;
    logic                load_en;
    logic                xfer;
    logic [DATA_W-1:0]   gnt_data;
    logic [SEL_SPAN-1:0] valid_ext;

    rr_pick #(
        .NUM_CH (NUM_CH),
        .SEL_W  (SEL_W)
    ) u_rr_pick (
        .req     (in_valid),
        .ptr     (ptr),
        .gnt     (rr_gnt),
        .gnt_vld (rr_vld)
    );

    // Zero-padded valids make an out-of-range sel read as "not valid".
    always_comb begin
        valid_ext               = '0;
        valid_ext[NUM_CH-1:0]   = in_valid;
    end

    always_comb begin
        if (mode == MODE_RR) begin
            gnt     = rr_gnt;
            gnt_vld = rr_vld;
        end else begin
            gnt     = sel;
            gnt_vld = valid_ext[sel];
        end
    end

    assign load_en   = (state == ST_EMPTY) | out_ready;
    assign out_valid = (state == ST_FULL);

    always_comb begin
        in_ready = '0;
        gnt_data = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (gnt == SEL_W'(i)) begin
                in_ready[i] = load_en & gnt_vld;
                gnt_data    = in_data[i*DATA_W +: DATA_W];
            end
        end
    end

    assign xfer = |(in_ready & in_valid);

    always_comb begin
        state_nxt = state;
        case (state)
            ST_EMPTY: if (xfer)               state_nxt = ST_FULL;
            ST_FULL:  if (out_ready && !xfer) state_nxt = ST_EMPTY;
            default:                          state_nxt = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_EMPTY;
            out_data <= '0;
            out_ch   <= '0;
            ptr      <= '0;
        end else begin
            state <= state_nxt;
            if (xfer) begin
                out_data <= gnt_data;
                out_ch   <= gnt;
                // Explicit wrap so non-power-of-two channel counts rotate correctly.
                if (mode == MODE_RR) begin
                    ptr <= (gnt == SEL_W'(NUM_CH-1)) ? '0 : gnt + 1'b1;
                end
            end
        end
    end

`ifdef MUX_STALL_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (out_valid && !out_ready && (stall_cnt != {STALL_W{1'b1}})) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_mux_nx1_rr.sv
// tb/tb_mux_nx1_rr.sv - self-checking bench for mux_nx1_rr (4-channel and 3-channel instances)
module tb_mux_nx1_rr;

    logic        clk = 1'b0;
    logic        rst;
    logic        mode;
    logic [1:0]  sel;
    logic [3:0]  in_valid;
    logic [31:0] in_data;
    logic [3:0]  in_ready;
    logic        out_valid;
    logic [7:0]  out_data;
    logic [1:0]  out_ch;
    logic        out_ready;

    logic        mode3;
    logic [1:0]  sel3;
    logic [2:0]  in_valid3;
    logic [23:0] in_data3;
    logic [2:0]  in_ready3;
    logic        out_valid3;
    logic [7:0]  out_data3;
    logic [1:0]  out_ch3;
    logic        out_ready3;
`ifdef MUX_STALL_CNT_EN
    logic [15:0] stall_cnt;
    logic [15:0] stall_cnt3;
`endif

    int errors = 0;
    int checks = 0;

    bit          m_valid;
    logic [7:0]  m_data;
    int          m_ch;
    int          m_ptr;
    int          m_stall;
    int          last_g;

    always #5 clk = ~clk;

    mux_nx1_rr #(.NUM_CH(4), .DATA_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .mode      (mode),
        .sel       (sel),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ch    (out_ch),
`ifdef MUX_STALL_CNT_EN
        .stall_cnt (stall_cnt),
`endif
        .out_ready (out_ready)
    );

    mux_nx1_rr #(.NUM_CH(3), .DATA_W(8)) dut3 (
        .clk       (clk),
        .rst       (rst),
        .mode      (mode3),
        .sel       (sel3),
        .in_valid  (in_valid3),
        .in_data   (in_data3),
        .in_ready  (in_ready3),
        .out_valid (out_valid3),
        .out_data  (out_data3),
        .out_ch    (out_ch3),
`ifdef MUX_STALL_CNT_EN
        .stall_cnt (stall_cnt3),
`endif
        .out_ready (out_ready3)
    );

    // Reference grant: fixed picks sel if in range and valid; round-robin scans from ptr with modular wrap.
    task automatic pick(input bit md, input int s, input logic [3:0] v, input int p,
                        output bit gv, output int g);
        gv = 1'b0;
        g  = 0;
        if (!md) begin
            if (s < 4 && v[s]) begin
                gv = 1'b1;
                g  = s;
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (!gv && v[(p + k) % 4]) begin
                    gv = 1'b1;
                    g  = (p + k) % 4;
                end
            end
        end
    endtask

    task automatic model_reset();
        m_valid = 1'b0;
        m_data  = 8'h00;
        m_ch    = 0;
        m_ptr   = 0;
        m_stall = 0;
    endtask

    task automatic step(input string tag);
        bit         gv;
        int         g;
        bit         xfer;
        logic [3:0] exp_rdy;
        #1;
        pick(mode, int'(sel), in_valid, m_ptr, gv, g);
        xfer    = (!m_valid || out_ready) && gv;
        exp_rdy = xfer ? 4'(1 << g) : 4'b0000;
        checks++;
        if (in_ready !== exp_rdy) begin
            errors++;
            $display("FAIL %s in_ready got=%b exp=%b", tag, in_ready, exp_rdy);
        end
        if (m_valid && !out_ready && m_stall != 16'hFFFF) m_stall++;
        if (xfer) begin
            m_valid = 1'b1;
            m_data  = in_data[g*8 +: 8];
            m_ch    = g;
            if (mode) m_ptr = (g + 1) % 4;
        end else if (out_ready) begin
            m_valid = 1'b0;
        end
        last_g = g;
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== m_valid || out_data !== m_data || out_ch !== 2'(m_ch)) begin
            errors++;
            $display("FAIL %s out got=%b/%h/%0d exp=%b/%h/%0d",
                     tag, out_valid, out_data, out_ch, m_valid, m_data, m_ch);
        end
`ifdef MUX_STALL_CNT_EN
        checks++;
        if (stall_cnt !== 16'(m_stall)) begin
            errors++;
            $display("FAIL %s stall_cnt got=%0d exp=%0d", tag, stall_cnt, m_stall);
        end
`endif
    endtask

    task automatic do_reset();
        #2;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        mode = 1'b0; sel = 2'd0; in_valid = 4'b0001; in_data = 32'h0000_003C; out_ready = 1'b0;
        step("reset_load");
        in_valid = 4'b0000;
        #3;
        rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_data !== 8'h00 || out_ch !== 2'd0) begin
            errors++;
            $display("FAIL reset_async got=%b/%h/%0d exp=0/00/0", out_valid, out_data, out_ch);
        end
        checks++;
        if (in_ready !== 4'b0000 || in_ready3 !== 3'b000 || out_valid3 !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready got=%b/%b/%b exp=0000/000/0", in_ready, in_ready3, out_valid3);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_fixed();
        mode = 1'b0; sel = 2'd2; in_valid = 4'b1111; out_ready = 1'b1;
        in_data = $urandom();
        in_data[23:16] = 8'hA5;
        #1;
        checks++;
        if (in_ready !== 4'b0100) begin
            errors++;
            $display("FAIL fixed_ready got=%b exp=0100", in_ready);
        end
        step("fixed_xfer");
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'hA5 || out_ch !== 2'd2) begin
            errors++;
            $display("FAIL fixed_out got=%b/%h/%0d exp=1/a5/2", out_valid, out_data, out_ch);
        end
    endtask

    task automatic test_rr_all();
        int exp_g[5] = '{0, 1, 2, 3, 0};
        mode = 1'b1; in_valid = 4'b1111; out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            in_data = $urandom();
            step("rr_all");
            checks++;
            if (out_ch !== 2'(exp_g[k])) begin
                errors++;
                $display("FAIL rr_all_seq[%0d] got=%0d exp=%0d", k, out_ch, exp_g[k]);
            end
        end
    endtask

    task automatic test_rr_sparse();
        mode = 1'b1; out_ready = 1'b1;
        in_valid = 4'b0100; in_data = $urandom();
        step("rr_to_ptr3");
        in_valid = 4'b0010; in_data = $urandom();
        step("rr_sparse");
        checks++;
        if (out_ch !== 2'd1) begin
            errors++;
            $display("FAIL rr_sparse_gnt got=%0d exp=1", out_ch);
        end
        in_valid = 4'b1111; in_data = $urandom();
        step("rr_after_sparse");
        checks++;
        if (out_ch !== 2'd2) begin
            errors++;
            $display("FAIL rr_ptr2 got=%0d exp=2", out_ch);
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] hold_d;
        logic [1:0] hold_c;
        do_reset();
        mode = 1'b0; sel = 2'd1; in_valid = 4'b0010; in_data = $urandom(); out_ready = 1'b1;
        step("bp_load");
        hold_d = in_data[15:8];
        hold_c = 2'd1;
        out_ready = 1'b0; in_valid = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            in_data = $urandom();
            sel     = 2'($urandom_range(0, 3));
            step("bp_stall");
            checks++;
            if (out_data !== hold_d || out_ch !== hold_c || out_valid !== 1'b1) begin
                errors++;
                $display("FAIL bp_hold got=%h/%0d exp=%h/%0d", out_data, out_ch, hold_d, hold_c);
            end
        end
`ifdef MUX_STALL_CNT_EN
        checks++;
        if (stall_cnt !== 16'd5) begin
            errors++;
            $display("FAIL bp_stall_cnt got=%0d exp=5", stall_cnt);
        end
`endif
        out_ready = 1'b1; sel = 2'd3; in_data = $urandom();
        hold_d = in_data[31:24];
        step("bp_release");
        checks++;
        if (out_valid !== 1'b1 || out_data !== hold_d || out_ch !== 2'd3) begin
            errors++;
            $display("FAIL bp_release got=%b/%h/%0d exp=1/%h/3", out_valid, out_data, out_ch, hold_d);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 300; k++) begin
            mode      = 1'($urandom_range(0, 1));
            sel       = 2'($urandom_range(0, 3));
            in_valid  = 4'($urandom());
            in_data   = $urandom();
            out_ready = ($urandom_range(0, 3) != 0);
            step("random");
        end
    endtask

    task automatic test_invalid_sel();
        do_reset();
        mode3 = 1'b0; sel3 = 2'd3; in_valid3 = 3'b111; in_data3 = 24'h33_22_11; out_ready3 = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++;
            if (in_ready3 !== 3'b000) begin
                errors++;
                $display("FAIL bad_sel_ready got=%b exp=000", in_ready3);
            end
            @(posedge clk);
            #1;
            checks++;
            if (out_valid3 !== 1'b0) begin
                errors++;
                $display("FAIL bad_sel_valid got=%b exp=0", out_valid3);
            end
        end
        mode3 = 1'b1; in_valid3 = 3'b110;
        #1;
        checks++;
        if (in_ready3 !== 3'b010) begin
            errors++;
            $display("FAIL bad_sel_rr_ready got=%b exp=010", in_ready3);
        end
        @(posedge clk);
        #1;
        checks++;
        if (out_valid3 !== 1'b1 || out_ch3 !== 2'd1 || out_data3 !== 8'h22) begin
            errors++;
            $display("FAIL bad_sel_rr_out got=%b/%0d/%h exp=1/1/22", out_valid3, out_ch3, out_data3);
        end
        in_valid3 = 3'b000;
    endtask

    initial begin
        rst = 1'b1;
        mode = 1'b0; sel = 2'd0; in_valid = '0; in_data = '0; out_ready = 1'b0;
        mode3 = 1'b0; sel3 = 2'd0; in_valid3 = '0; in_data3 = '0; out_ready3 = 1'b0;
        model_reset();
        last_g = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        test_reset();
        test_fixed();
        test_rr_all();
        test_rr_sparse();
        test_backpressure();
        test_random();
        test_invalid_sel();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
